// File: rtl/fb_pixel_fetcher_if.sv
// DDR address/read-data FIFO and video stream bundle for the frame-buffer pixel fetcher.
// master = fetcher side, slave = FIFO/video side.
interface fb_pixel_fetcher_if;
   logic         af_full;
   logic [2:0]   af_cmd_din;
   logic [30:0]  af_addr_din;
   logic         af_wr_en;
   logic         rdf_valid;
   logic [127:0] rdf_dout;
   logic         rdf_rd_en;
   logic         video_valid;
   logic         video_ready;
   logic [23:0]  video_pixel;

   modport master (
      input  af_full, rdf_valid, rdf_dout, video_ready,
      output af_cmd_din, af_addr_din, af_wr_en, rdf_rd_en, video_valid, video_pixel
   );

   modport slave (
      output af_full, rdf_valid, rdf_dout, video_ready,
      input  af_cmd_din, af_addr_din, af_wr_en, rdf_rd_en, video_valid, video_pixel
   );
endinterface

// File: rtl/fb_pixel_fetcher.sv
// Streams a raster frame from the DDR frame buffer into a valid/ready pixel stream.
// Optional FB_FETCH_UNDERFLOW_CNT_EN adds a saturating starvation counter on underflow_count.
//
// state  | meaning
// IDLE   | no frame active
// FETCH  | issuing read commands and streaming pixels
// FINISH | all commands issued, draining remaining pixels
// FLUSH  | restart pending, dropping in-flight beats of the abandoned frame
module fb_pixel_fetcher #(
   parameter int H_ACTIVE  = 800,
   parameter int V_ACTIVE  = 600,
   parameter int BUF_WORDS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [30:0]          frame_base,
   input  logic                 frame_start,
   fb_pixel_fetcher_if.master   bus,
   output logic                 frame_done,
   output logic                 busy,
   output logic [15:0]          underflow_count
);

   localparam int AW = $clog2(BUF_WORDS);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;
   localparam logic [1:0] S_FLUSH  = 2'd3;

   logic [1:0]    state;
   logic [30:0]   base_q;
   logic [9:0]    cmd_x, cmd_y, pix_x, pix_y;
   logic [AW:0]   outstanding, buf_cnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [1:0]    pix_idx;
   logic [95:0]   buf_mem [BUF_WORDS];
   logic [95:0]   head_word;
   logic [23:0]   pix_sel;
   logic [AW+2:0] free_words, need_words;
   logic          active, cmd_ok, last_cmd, buf_wr, hs, word_done, last_pix;
   logic          unused_alpha;

   assign active     = (state == S_FETCH) || (state == S_FINISH);
   assign free_words = (AW+3)'(BUF_WORDS) - (AW+3)'(buf_cnt);
   assign need_words = ((AW+3)'(outstanding) + (AW+3)'(1)) << 1;
   assign cmd_ok     = (state == S_FETCH) && !bus.af_full && (free_words >= need_words);
   assign last_cmd   = (cmd_x == 10'(H_ACTIVE-8)) && (cmd_y == 10'(V_ACTIVE-1));

   assign bus.af_wr_en    = cmd_ok;
   assign bus.af_cmd_din  = 3'b001;
   assign bus.af_addr_din = base_q | {12'd0, cmd_y, cmd_x[9:3], 2'b00};

   // Space for every requested beat is reserved at issue time, so rdf is never back-pressured.
   assign bus.rdf_rd_en = bus.rdf_valid && (outstanding != '0);
   assign buf_wr        = bus.rdf_rd_en && active && !frame_start;

   assign bus.video_valid = active && (buf_cnt != '0);
   assign hs        = bus.video_valid && bus.video_ready;
   assign word_done = hs && (pix_idx == 2'd3);
   assign last_pix  = (pix_x == 10'(H_ACTIVE-1)) && (pix_y == 10'(V_ACTIVE-1));
   assign busy      = (state != S_IDLE);

   assign head_word = buf_mem[rd_ptr];
   always_comb begin
      pix_sel = 24'd0;
      case (pix_idx)
         2'd0:    pix_sel = head_word[95:72];
         2'd1:    pix_sel = head_word[71:48];
         2'd2:    pix_sel = head_word[47:24];
         default: pix_sel = head_word[23:0];
      endcase
   end
   assign bus.video_pixel = bus.video_valid ? pix_sel : 24'd0;

   // Only the 24-bit RGB part of each 32-bit lane is kept in the buffer.
   assign unused_alpha = ^{bus.rdf_dout[127:120], bus.rdf_dout[95:88],
                           bus.rdf_dout[63:56], bus.rdf_dout[31:24]};

   always_ff @(posedge clk) begin
      if (buf_wr)
         buf_mem[wr_ptr] <= {bus.rdf_dout[119:96], bus.rdf_dout[87:64],
                             bus.rdf_dout[55:32], bus.rdf_dout[23:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         base_q      <= '0;
         cmd_x       <= '0;
         cmd_y       <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_idx     <= '0;
         outstanding <= '0;
         buf_cnt     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= hs && last_pix;

         case ({cmd_ok, bus.rdf_rd_en})
            2'b10:   outstanding <= outstanding + (AW+1)'(2);
            2'b01:   outstanding <= outstanding - (AW+1)'(1);
            2'b11:   outstanding <= outstanding + (AW+1)'(1);
            default: ;
         endcase

         if (frame_start) begin
            base_q  <= frame_base;
            cmd_x   <= '0;
            cmd_y   <= '0;
            pix_x   <= '0;
            pix_y   <= '0;
            pix_idx <= '0;
            buf_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state   <= (state == S_IDLE) ? S_FETCH : S_FLUSH;
         end else begin
            case (state)
               S_FETCH:  if (cmd_ok && last_cmd) state <= S_FINISH;
               S_FINISH: if (hs && last_pix) state <= S_IDLE;
               S_FLUSH:  if (outstanding == '0) state <= S_FETCH;
               default:  ;
            endcase

            if (cmd_ok) begin
               if (cmd_x == 10'(H_ACTIVE-8)) begin
                  cmd_x <= '0;
                  cmd_y <= cmd_y + 10'd1;
               end else begin
                  cmd_x <= cmd_x + 10'd8;
               end
            end

            if (buf_wr)
               wr_ptr <= wr_ptr + AW'(1);
            if (word_done)
               rd_ptr <= rd_ptr + AW'(1);
            case ({buf_wr, word_done})
               2'b10:   buf_cnt <= buf_cnt + (AW+1)'(1);
               2'b01:   buf_cnt <= buf_cnt - (AW+1)'(1);
               default: ;
            endcase

            if (hs) begin
               pix_idx <= pix_idx + 2'd1;
               if (pix_x == 10'(H_ACTIVE-1)) begin
                  pix_x <= '0;
                  pix_y <= pix_y + 10'd1;
               end else begin
                  pix_x <= pix_x + 10'd1;
               end
            end
         end
      end
   end

`ifdef FB_FETCH_UNDERFLOW_CNT_EN
   logic        first_seen;
   logic [15:0] uf_cnt;

   // Starvation only counts once the consumer has started receiving this frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_seen <= 1'b0;
         uf_cnt     <= '0;
      end else if (frame_start) begin
         first_seen <= 1'b0;
         uf_cnt     <= '0;
      end else begin
         if (hs)
            first_seen <= 1'b1;
         if (bus.video_ready && !bus.video_valid && active && first_seen && (uf_cnt != 16'hFFFF))
            uf_cnt <= uf_cnt + 16'd1;
      end
   end
   assign underflow_count = uf_cnt;
`else
   assign underflow_count = 16'h0000;
`endif

endmodule
